// File: rtl/ball_ctrl_if.sv
// Signal bundle for one ball controller. The frame, serve and paddle controls go in.
// The ball position, speed and miss events come out.
interface ball_ctrl_if;
   logic       refresh_tick;
   logic       start;
   logic       pause;
   logic [9:0] paddle1_y;
   logic [9:0] paddle2_y;
   logic [9:0] ball_x;
   logic [9:0] ball_y;
   logic [3:0] ball_speed;
   logic       active;
   logic       miss_left;
   logic       miss_right;

   modport master (
      output refresh_tick, start, pause, paddle1_y, paddle2_y,
      input  ball_x, ball_y, ball_speed, active, miss_left, miss_right
   );

   modport slave (
      input  refresh_tick, start, pause, paddle1_y, paddle2_y,
      output ball_x, ball_y, ball_speed, active, miss_left, miss_right
   );
endinterface

// File: rtl/ball_ctrl.sv
// Per-ball motion controller: a serve/move/miss FSM that advances the ball once per frame.
// Optional macro BALL_SPIN_EN makes the paddle contact point set the vertical direction on a hit.
module ball_ctrl #(
   parameter int TOP_MARGIN     = 25,
   parameter int BOTTOM_Y       = 472,
   parameter int INIT_X         = 316,
   parameter int INIT_Y         = 248,
   parameter int HITS_PER_LEVEL = 4,
   parameter int MISS_FRAMES    = 60
) (
   input logic        clk,
   input logic        reset,
   ball_ctrl_if.slave bus
);

   localparam int HIT_W  = $clog2(HITS_PER_LEVEL + 1);
   localparam int MISS_W = (MISS_FRAMES > 1) ? $clog2(MISS_FRAMES) : 1;

   localparam logic [10:0] TOP_Y        = 11'(TOP_MARGIN);
   localparam logic [10:0] BOT_Y        = 11'(BOTTOM_Y);
   localparam logic [10:0] LEFT_PAD_X   = 11'd41;
   localparam logic [10:0] LEFT_WALL_X  = 11'd32;
   localparam logic [10:0] RIGHT_PAD_X  = 11'd592;
   localparam logic [10:0] RIGHT_WALL_X = 11'd601;
   localparam logic [10:0] BALL_SIZE    = 11'd7;
   localparam logic [10:0] PAD_SPAN     = 11'd72;
   localparam logic [9:0]  SERVE_X      = 10'(INIT_X);
   localparam logic [9:0]  SERVE_Y      = 10'(INIT_Y);
   localparam logic [3:0]  SPEED_MIN    = 4'd2;
   localparam logic [3:0]  SPEED_MAX    = 4'd5;

   typedef enum logic [1:0] {SERVE, MOVE, MISS} state_t;

   state_t            r_state;
   state_t            w_nextState;

   logic [9:0]        r_ballX;
   logic [9:0]        r_ballY;
   logic [3:0]        r_speed;
   logic [HIT_W-1:0]  r_hitCnt;
   logic [MISS_W-1:0] r_missCnt;
   logic              r_dxRight;
   logic              r_dyDown;
   logic              r_active;
   logic              r_missLeft;
   logic              r_missRight;

   logic [9:0]        w_nxtX;
   logic [9:0]        w_nxtY;
   logic [3:0]        w_nxtSpeed;
   logic [HIT_W-1:0]  w_nxtHitCnt;
   logic [HIT_W-1:0]  w_hitInc;
   logic [MISS_W-1:0] w_nxtMissCnt;
   logic              w_nxtDxRight;
   logic              w_nxtDyDown;
   logic              w_nxtActive;
   logic              w_nxtMissLeft;
   logic              w_nxtMissRight;

   logic [10:0]       w_x;
   logic [10:0]       w_y;
   logic [10:0]       w_s;
   logic [10:0]       w_xLeft;
   logic [10:0]       w_xRight;
   logic [10:0]       w_yDown;
   logic [9:0]        w_yUp;
   logic [10:0]       w_p1Top;
   logic [10:0]       w_p2Top;
   logic              w_moveTick;
   logic              w_missTick;
   logic              w_missDone;
   logic              w_ov1;
   logic              w_ov2;
   logic              w_hitLeft;
   logic              w_hitRight;
   logic              w_hit;
   logic              w_missLeftEv;
   logic              w_missRightEv;

   // Do all geometry in 11 bits so that subtractions near the walls cannot wrap.
   assign w_x      = {1'b0, r_ballX};
   assign w_y      = {1'b0, r_ballY};
   assign w_s      = {7'd0, r_speed};
   assign w_xLeft  = w_x - w_s;
   assign w_xRight = w_x + w_s;
   assign w_yDown  = w_y + w_s;
   assign w_yUp    = r_ballY - {6'd0, r_speed};
   assign w_p1Top  = {1'b0, bus.paddle1_y} + TOP_Y;
   assign w_p2Top  = {1'b0, bus.paddle2_y} + TOP_Y;

   assign w_ov1 = (w_y + BALL_SIZE >= w_p1Top) && (w_y <= w_p1Top + PAD_SPAN);
   assign w_ov2 = (w_y + BALL_SIZE >= w_p2Top) && (w_y <= w_p2Top + PAD_SPAN);

   assign w_hitLeft     = !r_dxRight && (w_x >= LEFT_PAD_X) && (w_xLeft <= LEFT_PAD_X) && w_ov1;
   assign w_missLeftEv  = !r_dxRight && !w_hitLeft && (w_x < LEFT_WALL_X + w_s);
   assign w_hitRight    = r_dxRight && (w_x <= RIGHT_PAD_X) && (w_xRight >= RIGHT_PAD_X) && w_ov2;
   assign w_missRightEv = r_dxRight && !w_hitRight && (w_xRight > RIGHT_WALL_X);
   assign w_hit         = w_hitLeft || w_hitRight;
   assign w_hitInc      = r_hitCnt + HIT_W'(1);

   assign w_moveTick = (r_state == MOVE) && bus.refresh_tick && !bus.pause;
   assign w_missTick = (r_state == MISS) && bus.refresh_tick && !bus.pause;
   assign w_missDone = (r_missCnt == MISS_W'(MISS_FRAMES - 1));

`ifdef BALL_SPIN_EN
   logic [10:0] w_yMid;
   logic [10:0] w_padMid;
   assign w_yMid   = w_y + 11'd4;
   assign w_padMid = (w_hitLeft ? w_p1Top : w_p2Top) + 11'd36;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= SERVE;
      end else begin
         r_state <= w_nextState;
      end
   end

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         SERVE:   if (bus.start) w_nextState = MOVE;
         MOVE:    if (w_moveTick && (w_missLeftEv || w_missRightEv)) w_nextState = MISS;
         MISS:    if (w_missTick && w_missDone) w_nextState = SERVE;
         default: w_nextState = SERVE;
      endcase
   end

   // Next register values. Motion rules all use the position from before the update.
   always_comb begin
      w_nxtX         = r_ballX;
      w_nxtY         = r_ballY;
      w_nxtSpeed     = r_speed;
      w_nxtHitCnt    = r_hitCnt;
      w_nxtMissCnt   = r_missCnt;
      w_nxtDxRight   = r_dxRight;
      w_nxtDyDown    = r_dyDown;
      w_nxtMissLeft  = 1'b0;
      w_nxtMissRight = 1'b0;
      w_nxtActive    = (w_nextState == MOVE);
      case (r_state)
         MOVE: begin
            if (w_moveTick) begin
               if (r_dyDown) begin
                  if (w_yDown >= BOT_Y) begin
                     w_nxtY      = BOT_Y[9:0];
                     w_nxtDyDown = 1'b0;
                  end else begin
                     w_nxtY = w_yDown[9:0];
                  end
               end else if (w_y < TOP_Y + w_s) begin
                  w_nxtY      = TOP_Y[9:0];
                  w_nxtDyDown = 1'b1;
               end else begin
                  w_nxtY = w_yUp;
               end

               if (w_hitLeft) begin
                  w_nxtX       = LEFT_PAD_X[9:0];
                  w_nxtDxRight = 1'b1;
               end else if (w_missLeftEv) begin
                  w_nxtX        = LEFT_WALL_X[9:0];
                  w_nxtMissLeft = 1'b1;
                  w_nxtMissCnt  = '0;
               end else if (!r_dxRight) begin
                  w_nxtX = w_xLeft[9:0];
               end else if (w_hitRight) begin
                  w_nxtX       = RIGHT_PAD_X[9:0];
                  w_nxtDxRight = 1'b0;
               end else if (w_missRightEv) begin
                  w_nxtX         = RIGHT_WALL_X[9:0];
                  w_nxtMissRight = 1'b1;
                  w_nxtMissCnt   = '0;
               end else begin
                  w_nxtX = w_xRight[9:0];
               end

               if (w_hit) begin
`ifdef BALL_SPIN_EN
                  if (w_yMid < w_padMid) begin
                     w_nxtDyDown = 1'b0;
                  end else if (w_yMid > w_padMid) begin
                     w_nxtDyDown = 1'b1;
                  end
`endif
                  if (w_hitInc == HIT_W'(HITS_PER_LEVEL)) begin
                     w_nxtHitCnt = '0;
                     if (r_speed < SPEED_MAX) w_nxtSpeed = r_speed + 4'd1;
                  end else begin
                     w_nxtHitCnt = w_hitInc;
                  end
               end
            end
         end
         MISS: begin
            // dx is left alone here: after a miss it already points at the player who missed.
            if (w_missTick) begin
               if (w_missDone) begin
                  w_nxtX       = SERVE_X;
                  w_nxtY       = SERVE_Y;
                  w_nxtSpeed   = SPEED_MIN;
                  w_nxtHitCnt  = '0;
                  w_nxtMissCnt = '0;
               end else begin
                  w_nxtMissCnt = r_missCnt + MISS_W'(1);
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_ballX     <= SERVE_X;
         r_ballY     <= SERVE_Y;
         r_speed     <= SPEED_MIN;
         r_hitCnt    <= '0;
         r_missCnt   <= '0;
         r_dxRight   <= 1'b1;
         r_dyDown    <= 1'b1;
         r_active    <= 1'b0;
         r_missLeft  <= 1'b0;
         r_missRight <= 1'b0;
      end else begin
         r_ballX     <= w_nxtX;
         r_ballY     <= w_nxtY;
         r_speed     <= w_nxtSpeed;
         r_hitCnt    <= w_nxtHitCnt;
         r_missCnt   <= w_nxtMissCnt;
         r_dxRight   <= w_nxtDxRight;
         r_dyDown    <= w_nxtDyDown;
         r_active    <= w_nxtActive;
         r_missLeft  <= w_nxtMissLeft;
         r_missRight <= w_nxtMissRight;
      end
   end

   assign bus.ball_x     = r_ballX;
   assign bus.ball_y     = r_ballY;
   assign bus.ball_speed = r_speed;
   assign bus.active     = r_active;
   assign bus.miss_left  = r_missLeft;
   assign bus.miss_right = r_missRight;

endmodule

// File: tb/tb_ball_ctrl.sv
// Directed bench for ball_ctrl. It follows one hand-traced trajectory, then runs the
// speed-saturation, miss/serve and reset scenarios.
module tb_ball_ctrl;

   logic clk = 1'b0;
   logic reset;
   int   total = 0;
   int   bad = 0;
   int   hits;

   ball_ctrl_if bus ();

   ball_ctrl dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [15:0] observed, input int expected);
      total++;
      assert (observed === 16'(expected)) else begin
         bad++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   // Inputs change on the falling edge. Outputs are sampled on the next falling edge,
   // half a cycle after the rising edge that captured the inputs.
   task automatic applyStimulus(input logic tickIn, input logic startIn, input logic pauseIn,
                                input logic resetIn);
      @(negedge clk);
      bus.refresh_tick = tickIn;
      bus.start        = startIn;
      bus.pause        = pauseIn;
      reset            = resetIn;
      @(negedge clk);
      bus.refresh_tick = 1'b0;
      bus.start        = 1'b0;
      bus.pause        = 1'b0;
      reset            = 1'b0;
   endtask

   task automatic tick(input int n);
      repeat (n) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic checkPos(input string tag, input int x, input int y);
      checkOutput({tag, "_x"}, 16'(bus.ball_x), x);
      checkOutput({tag, "_y"}, 16'(bus.ball_y), y);
   endtask

   initial begin
      reset            = 1'b1;
      bus.refresh_tick = 1'b0;
      bus.start        = 1'b0;
      bus.pause        = 1'b0;
      bus.paddle1_y    = 10'd100;
      bus.paddle2_y    = 10'd400;
      repeat (2) @(negedge clk);
      reset = 1'b0;

      checkPos("rst", 316, 248);
      checkOutput("rst_speed", 16'(bus.ball_speed), 2);
      checkOutput("rst_active", 16'(bus.active), 0);
      checkOutput("rst_missl", 16'(bus.miss_left), 0);
      checkOutput("rst_missr", 16'(bus.miss_right), 0);

      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
      checkOutput("serve_active", 16'(bus.active), 1);
      checkOutput("serve_tick_ignored", 16'(bus.ball_x), 316);

      tick(1);
      checkPos("t1", 318, 250);
      checkOutput("t1_speed", 16'(bus.ball_speed), 2);
      tick(110);
      checkPos("t111", 538, 470);
      tick(1);
      checkPos("t112_bottom", 540, 472);
      tick(26);
      checkPos("t138_rhit", 592, 420);
      tick(197);
      checkPos("t335", 198, 26);
      tick(1);
      checkPos("t336_top", 196, 25);
      tick(1);
      checkPos("t337", 194, 27);

      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
      checkPos("paused", 194, 27);
      checkOutput("paused_active", 16'(bus.active), 1);

      tick(77);
      checkPos("t414_lhit", 41, 181);
      tick(146);
      checkPos("t560_bottom", 333, 472);
      bus.paddle2_y = 10'd180;
      tick(130);
      checkPos("t690_rhit", 592, 212);
      checkOutput("t690_speed", 16'(bus.ball_speed), 2);
      bus.paddle1_y = 10'd300;
      tick(276);
      checkPos("t966_hit4", 41, 389);
      checkOutput("t966_speed", 16'(bus.ball_speed), 3);
      tick(1);
      checkPos("t967", 44, 392);

      // Paddles follow the ball so every wall approach becomes a hit.
      hits = 4;
      for (int i = 0; i < 6000 && hits < 16; i++) begin
         bus.paddle1_y = bus.ball_y - 10'd25;
         bus.paddle2_y = bus.ball_y - 10'd25;
         applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
         if (bus.ball_x == 10'd41 || bus.ball_x == 10'd592) begin
            hits++;
            if (hits == 8)  checkOutput("hit8_speed", 16'(bus.ball_speed), 4);
            if (hits == 12) checkOutput("hit12_speed", 16'(bus.ball_speed), 5);
            if (hits == 16) checkOutput("hit16_speed_sat", 16'(bus.ball_speed), 5);
         end
      end
      checkOutput("hits_reached", 16'(hits), 16);
      checkOutput("track_active", 16'(bus.active), 1);

      for (int i = 0; i < 3000 && bus.active === 1'b1; i++) begin
         bus.paddle2_y = bus.ball_y - 10'd25;
         bus.paddle1_y = (bus.ball_y >= 10'd240) ? 10'd0 : 10'd380;
         applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      end
      checkOutput("missl_active", 16'(bus.active), 0);
      checkOutput("missl_x", 16'(bus.ball_x), 32);
      checkOutput("missl_pulse", 16'(bus.miss_left), 1);
      checkOutput("missl_no_r", 16'(bus.miss_right), 0);
      @(negedge clk);
      checkOutput("missl_one_cycle", 16'(bus.miss_left), 0);

      tick(30);
      repeat (10) applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
      tick(29);
      checkOutput("miss59_frozen", 16'(bus.ball_x), 32);
      tick(1);
      checkPos("reserve", 316, 248);
      checkOutput("reserve_speed", 16'(bus.ball_speed), 2);
      checkOutput("reserve_active", 16'(bus.active), 0);

      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
      checkOutput("start_paused", 16'(bus.active), 1);
      tick(1);
      checkOutput("serve_dx_left", 16'(bus.ball_x), 314);

      bus.paddle2_y = 10'd0;
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
      tick(142);
      checkPos("r142", 600, 412);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
      checkPos("rst_mid", 316, 248);
      checkOutput("rst_mid_speed", 16'(bus.ball_speed), 2);
      checkOutput("rst_mid_active", 16'(bus.active), 0);
      checkOutput("rst_mid_missr", 16'(bus.miss_right), 0);
      checkOutput("rst_mid_missl", 16'(bus.miss_left), 0);

      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
      tick(1);
      checkPos("rst_dir", 318, 250);
      tick(141);
      checkPos("r142b", 600, 412);
      tick(1);
      checkPos("missr", 601, 410);
      checkOutput("missr_pulse", 16'(bus.miss_right), 1);
      checkOutput("missr_no_l", 16'(bus.miss_left), 0);
      checkOutput("missr_active", 16'(bus.active), 0);
      @(negedge clk);
      checkOutput("missr_one_cycle", 16'(bus.miss_right), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
